// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: takes WIDTH-bit words over valid/ready and shifts
// them out one bit per clock, with zero-gap streaming between consecutive words.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_bit,
    output logic             bit_valid,
    output logic             last_bit,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] shreg_reg;
    logic [CW-1:0]    cnt_reg;
    logic             ser_bit_reg;
    logic             bit_valid_reg;
    logic             last_bit_reg;
    logic             busy_reg;

    // shreg holds the bits still to be sent, next one at the outgoing end.
    logic             load_first;
    logic [WIDTH-1:0] load_rest;
    logic             shreg_first;
    logic [WIDTH-1:0] shreg_rest;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign load_first  = din[WIDTH-1];
            assign load_rest   = {din[WIDTH-2:0], 1'b0};
            assign shreg_first = shreg_reg[WIDTH-1];
            assign shreg_rest  = {shreg_reg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign load_first  = din[0];
            assign load_rest   = {1'b0, din[WIDTH-1:1]};
            assign shreg_first = shreg_reg[0];
            assign shreg_rest  = {1'b0, shreg_reg[WIDTH-1:1]};
        end
    endgenerate

    assign din_ready = !busy_reg || last_bit_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            shreg_reg     <= '0;
            cnt_reg       <= '0;
            ser_bit_reg   <= IDLE_BIT;
            bit_valid_reg <= 1'b0;
            last_bit_reg  <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (din_valid) begin
                        state_reg     <= SHIFT;
                        shreg_reg     <= load_rest;
                        cnt_reg       <= '0;
                        ser_bit_reg   <= load_first;
                        bit_valid_reg <= 1'b1;
                        last_bit_reg  <= 1'b0;
                        busy_reg      <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (last_bit_reg) begin
                        if (din_valid) begin
                            // Reload on the final bit so words stream back-to-back.
                            shreg_reg    <= load_rest;
                            cnt_reg      <= '0;
                            ser_bit_reg  <= load_first;
                            last_bit_reg <= 1'b0;
                        end else begin
                            state_reg     <= IDLE;
                            cnt_reg       <= '0;
                            ser_bit_reg   <= IDLE_BIT;
                            bit_valid_reg <= 1'b0;
                            last_bit_reg  <= 1'b0;
                            busy_reg      <= 1'b0;
                        end
                    end else begin
                        shreg_reg    <= shreg_rest;
                        cnt_reg      <= cnt_reg + CW'(1);
                        ser_bit_reg  <= shreg_first;
                        last_bit_reg <= (cnt_reg == CW'(WIDTH - 2));
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ser_bit   = ser_bit_reg;
    assign bit_valid = bit_valid_reg;
    assign last_bit  = last_bit_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB-first and LSB-first instances share one stimulus stream
// and are checked every cycle against a bit-queue reference model plus directed vectors.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;

    logic m_ready, m_ser, m_bv, m_last, m_busy;
    logic l_ready, l_ser, l_bv, l_last, l_busy;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(m_ready), .ser_bit(m_ser), .bit_valid(m_bv),
        .last_bit(m_last), .busy(m_busy)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(l_ready), .ser_bit(l_ser), .bit_valid(l_bv),
        .last_bit(l_last), .busy(l_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Reference model: the bits still owed on the wire, front = bit on ser_bit now.
    bit qm[$];
    bit ql[$];
    bit check_en = 1'b0;

    logic [4:0] sm, sl;     // sampled {ser, bit_valid, last_bit, busy, din_ready}
    logic [4:0] hist = '0;  // last five ser_bit values seen by a downstream detector
    int         det_cnt = 0;

    typedef struct {
        logic [7:0] din;
        logic [7:0] seq_msb;  // bits in wire order, first sent at [7]
        logic [7:0] seq_lsb;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] exp_of(input bit q[$]);
        logic [4:0] e;
        if (q.size() == 0) e = 5'b00001;
        else e = {q[0], 1'b1, (q.size() == 1), 1'b1, (q.size() == 1)};
        return e;
    endfunction

    task automatic model_update();
        bit rdy;
        if (rst) begin
            qm.delete();
            ql.delete();
            hist = '0;
        end else begin
            rdy = (qm.size() <= 1);
            if (qm.size() > 0) void'(qm.pop_front());
            if (ql.size() > 0) void'(ql.pop_front());
            if (rdy && din_valid) begin
                for (int k = 0; k < 8; k++) begin
                    qm.push_back(din[7-k]);
                    ql.push_back(din[k]);
                end
            end
        end
    endtask

    // One clock: sample and check at the falling edge, update the model at the rising edge.
    task automatic tick();
        @(negedge clk);
        sm = {m_ser, m_bv, m_last, m_busy, m_ready};
        sl = {l_ser, l_bv, l_last, l_busy, l_ready};
        if (check_en) begin
            chk("model_msb", {27'd0, sm}, {27'd0, exp_of(qm)});
            chk("model_lsb", {27'd0, sl}, {27'd0, exp_of(ql)});
        end
        hist = {hist[3:0], m_ser};
        if (hist == 5'b10110) det_cnt++;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic send_word(input logic [7:0] w, output logic [7:0] s_m,
                             output logic [7:0] s_l, output logic [7:0] lastp,
                             output logic [7:0] bvp);
        din = w;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            s_m[7-k]   = sm[4];
            s_l[7-k]   = sl[4];
            bvp[7-k]   = sm[3] & sl[3];
            lastp[7-k] = sm[2] & sl[2];
        end
    endtask

    initial begin
        logic [7:0]  s_m, s_l, lastp, bvp;
        logic [15:0] str, bv16, rdy16;
        int          d0;

        vecs[0] = '{8'hB6, 8'b10110110, 8'b01101101};
        vecs[1] = '{8'h0D, 8'b00001101, 8'b10110000};
        vecs[2] = '{8'h6C, 8'b01101100, 8'b00110110};
        vecs[3] = '{8'hFF, 8'b11111111, 8'b11111111};
        vecs[4] = '{8'h01, 8'b00000001, 8'b10000000};
        vecs[5] = '{8'h80, 8'b10000000, 8'b00000001};
        vecs[6] = '{8'hA5, 8'b10100101, 8'b10100101};

        rst = 1'b1;
        din = '0;
        din_valid = 1'b0;
        tick();
        rst = 1'b0;
        check_en = 1'b1;

        // Reset state
        tick();
        chk("reset_msb", {27'd0, sm}, 32'b00001);
        chk("reset_lsb", {27'd0, sl}, 32'b00001);

        // 0xB6 straight after reset: detector sees 10110 twice
        d0 = det_cnt;
        send_word(8'hB6, s_m, s_l, lastp, bvp);
        chk("b6_detect", det_cnt - d0, 2);

        for (int i = 0; i < 7; i++) begin
            send_word(vecs[i].din, s_m, s_l, lastp, bvp);
            chk($sformatf("vec%0d_msb", i), {24'd0, s_m}, {24'd0, vecs[i].seq_msb});
            chk($sformatf("vec%0d_lsb", i), {24'd0, s_l}, {24'd0, vecs[i].seq_lsb});
            chk($sformatf("vec%0d_last", i), {24'd0, lastp}, 32'h01);
            chk($sformatf("vec%0d_valid", i), {24'd0, bvp}, 32'hFF);
        end

        // Back-to-back words with din_valid held
        din = 8'hB6;
        din_valid = 1'b1;
        tick();
        din = 8'h6C;
        for (int k = 0; k < 16; k++) begin
            tick();
            str[15-k]   = sm[4];
            bv16[15-k]  = sm[3];
            rdy16[15-k] = sm[0];
            if (k == 8) din_valid = 1'b0;
        end
        chk("b2b_stream", {16'd0, str}, 32'hB66C);
        chk("b2b_valid", {16'd0, bv16}, 32'hFFFF);
        chk("b2b_ready", {16'd0, rdy16}, 32'h0101);
        tick();
        chk("b2b_idle", {27'd0, sm}, 32'b00001);

        // Reset after the third bit of 0xFF
        din = 8'hFF;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("midrst_msb", {27'd0, sm}, 32'b00001);
        chk("midrst_lsb", {27'd0, sl}, 32'b00001);
        send_word(8'h0D, s_m, s_l, lastp, bvp);
        chk("postrst_msb", {24'd0, s_m}, 32'h0D);
        chk("postrst_lsb", {24'd0, s_l}, 32'hB0);

        // Idle gap: no valid bits, idle level on the wire, no detection
        d0 = det_cnt;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("gap%0d", k), {30'd0, sm[4], sm[3]}, 32'd0);
        end
        chk("gap_detect", det_cnt - d0, 0);

        // Random stream checked against the queue model every cycle
        for (int n = 0; n < 600; n++) begin
            din       = 8'($urandom);
            din_valid = ($urandom_range(0, 9) < 6);
            rst       = ($urandom_range(0, 59) == 0);
            tick();
        end
        rst = 1'b0;
        din_valid = 1'b0;
        for (int k = 0; k < 10; k++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
